// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin/credit/selection controller with dispense handshake and 5-unit change return
module vend_controller #(
  parameter int PRICE0     = 15,
  parameter int PRICE1     = 20,
  parameter int PRICE2     = 25,
  parameter int PRICE3     = 30,
  parameter int MAX_CREDIT = 60,
  parameter int TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [3:0] coin_value,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       refund_req,
  input  logic       disp_ack,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic       sel_nack,
  output logic       disp_req,
  output logic [1:0] disp_id,
  output logic       change_out,
  output logic [5:0] credit,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic [CW-1:0] r_to_cnt;

  logic       w_coin_legal;
  logic [5:0] w_coin_amt;
  logic [6:0] w_coin_sum;
  logic [5:0] w_price;
  logic       w_front;
  logic       w_accept;
  logic       w_sel_ok;

  always_comb begin
    w_coin_legal = 1'b1;
    w_coin_amt   = 6'd0;
    case (coin_value)
      4'b0101: w_coin_amt = 6'd5;
      4'b1010: w_coin_amt = 6'd10;
      4'b1111: w_coin_amt = 6'd15;
      default: w_coin_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (sel_id)
      2'd0:    w_price = 6'(PRICE0);
      2'd1:    w_price = 6'(PRICE1);
      2'd2:    w_price = 6'(PRICE2);
      default: w_price = 6'(PRICE3);
    endcase
  end

  // Refund outranks coins and selections; a coin outranks a selection.
  assign w_coin_sum = {1'b0, credit} + {1'b0, w_coin_amt};
  assign w_front    = (r_state == S_IDLE) || (r_state == S_CREDIT);
  assign w_accept   = w_front && coin_valid && !refund_req && w_coin_legal &&
                      (w_coin_sum <= 7'(MAX_CREDIT));
  assign w_sel_ok   = w_front && sel_valid && !refund_req && !coin_valid && (credit >= w_price);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= '0;
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      sel_nack    <= 1'b0;
      disp_req    <= 1'b0;
      disp_id     <= 2'd0;
      change_out  <= 1'b0;
      credit      <= 6'd0;
      busy        <= 1'b0;
    end else begin
      coin_accept <= w_accept;
      coin_reject <= coin_valid && !w_accept;
      sel_nack    <= sel_valid && !w_sel_ok;
      change_out  <= 1'b0;
      busy        <= (r_state == S_VEND) || (r_state == S_CHANGE);
      r_to_cnt    <= (w_accept || sel_valid || r_state != S_CREDIT) ? '0 : r_to_cnt + CW'(1);

      case (r_state)
        S_IDLE, S_CREDIT: begin
          if (refund_req) begin
            if (r_state == S_CREDIT) r_state <= S_CHANGE;
          end else if (w_accept) begin
            credit  <= w_coin_sum[5:0];
            r_state <= S_CREDIT;
          end else if (w_sel_ok) begin
            credit   <= credit - w_price;
            disp_id  <= sel_id;
            disp_req <= 1'b1;
            r_state  <= S_VEND;
          end else if (r_state == S_CREDIT && !sel_valid && r_to_cnt == TO_LAST) begin
            r_state <= S_CHANGE;
          end
        end
        S_VEND: begin
          if (disp_ack) begin
            disp_req <= 1'b0;
            r_state  <= (credit != 6'd0) ? S_CHANGE : S_IDLE;
          end
        end
        S_CHANGE: begin
          if (credit != 6'd0) begin
            change_out <= 1'b1;
            credit     <= credit - 6'd5;
          end
          if (credit <= 6'd5) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction controller for the coin-operated vending path. It accepts coins of 5, 10 and 15 credit units into a saturating credit register and resolves product selections against a four-entry price table. It runs a request/acknowledge handshake with the dispense motor driver, then returns change one 5-unit coin per cycle. It sits between the coin validator / keypad front end and the dispense and change-hopper actuators.

## Interface
Parameters:
- PRICE0, default 15: price of product 0, in credit units.
- PRICE1, default 20: price of product 1.
- PRICE2, default 25: price of product 2.
- PRICE3, default 30: price of product 3.
- MAX_CREDIT, default 60: credit ceiling. Must be a multiple of 5 and ≤ 63.
- TIMEOUT, default 1000: idle-cycle limit in CREDIT before an automatic refund.

All prices are multiples of 5 and ≤ MAX_CREDIT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- coin_valid  in  1  one-cycle strobe; coin_value is valid
- coin_value  in  4  coin value; only 4'b0101 (5), 4'b1010 (10) and 4'b1111 (15) are legal
- sel_valid  in  1  one-cycle product-select strobe
- sel_id  in  2  selected product index
- refund_req  in  1  one-cycle strobe; return all credit
- disp_ack  in  1  motor driver done, single-cycle pulse
- coin_accept  out  1  pulse: coin added to credit
- coin_reject  out  1  pulse: coin returned, credit unchanged
- sel_nack  out  1  pulse: selection refused
- disp_req  out  1  level: dispense request
- disp_id  out  2  product index being dispensed, stable while disp_req=1
- change_out  out  1  pulse: eject one 5-unit coin
- credit  out  6  current credit
- busy  out  1  high in VEND or CHANGE

## Operation
- All outputs are registered. Reset drives every output to 0, credit to 0, the timeout counter to 0 and the state to IDLE.
- States:
  - IDLE: credit == 0.
  - CREDIT: credit > 0.
  - VEND: dispense handshake in progress.
  - CHANGE: returning credit.
- Coin handling, in IDLE or CREDIT:
  - Accept if coin_value is legal and credit + value ≤ MAX_CREDIT. Then credit += value, coin_accept pulses, and the state moves to CREDIT.
  - Otherwise coin_reject pulses.
  - Any coin_valid in VEND or CHANGE gives coin_reject.
- Selection handling, in IDLE or CREDIT:
  - If credit ≥ PRICE[sel_id]: credit -= price, disp_id ← sel_id, disp_req ← 1, state ← VEND.
  - Otherwise sel_nack pulses and the state is unchanged.
  - sel_valid in VEND or CHANGE gives sel_nack.
- Simultaneous events:
  - coin_valid and sel_valid in the same cycle: the coin is processed and the selection is refused with sel_nack.
  - refund_req together with either of them: refund_req has priority, and the coin is rejected and/or the selection nacked.
- Refund: refund_req in CREDIT moves to CHANGE. In IDLE, VEND or CHANGE it is ignored.
- VEND:
  - disp_req holds at 1 until disp_ack is sampled high.
  - On that edge disp_req ← 0. The state goes to CHANGE if credit > 0, otherwise to IDLE.
  - No timeout applies in VEND.
- CHANGE:
  - Each cycle: change_out ← 1 and credit -= 5.
  - On the edge where credit reaches 0, the state goes to IDLE.
  - A residual credit C produces exactly C/5 consecutive change_out pulses.
- Timeout:
  - The counter clears on entry to CREDIT, on any accepted coin and on any sel_valid.
  - Otherwise it increments in CREDIT.
  - When it reaches TIMEOUT-1, the state goes to CHANGE (automatic refund).
- Credit is always a multiple of 5 and never exceeds MAX_CREDIT. No wrap-around is possible.
- Reset mid-VEND: disp_req drops immediately and any pending credit is discarded. A reset mid-CHANGE stops change_out immediately.

## Timing
- coin_valid sampled at edge n: coin_accept or coin_reject is high in cycle n+1, and the updated credit is visible in cycle n+1.
- Successful sel_valid at edge n: disp_req=1 and the reduced credit are visible in cycle n+1.
- sel_nack is high in cycle n+1 for a sel_valid sampled at edge n.
- disp_ack sampled at edge m: disp_req=0 from cycle m+1, with the state CHANGE or IDLE from m+1. The first change_out is in cycle m+2.
- For refund_req or timeout at edge m: CHANGE from m+1, first change_out in m+2, last in m+1+C/5. busy falls in the cycle after the last change_out.
- disp_ack outside VEND is ignored. disp_ack in the same edge disp_req rises is not possible (disp_req must already be high when disp_ack is sampled).
- Back-to-back coins on consecutive cycles are all processed, with one result pulse each.

## Test plan
- Reset, then 5, 10, 15 on consecutive cycles -> three coin_accept pulses, credit 5, 15, 30. Then sel_id=2 -> disp_req=1, disp_id=2, credit=5. Then disp_ack -> one change_out, then credit=0 and IDLE.
- Credit 50, insert 15 -> coin_reject, credit stays 50. Insert coin_value 4'b0011 -> coin_reject.
- Credit 10, sel_id=0 (price 15) -> sel_nack, credit 10, no disp_req. Then refund_req -> two change_out pulses, credit 0.
- coin 10 and sel_valid in the same cycle from IDLE -> coin_accept and sel_nack, credit 10.
- TIMEOUT=8, insert 15 with no further activity -> CHANGE at the 8th idle cycle, then three change_out pulses.
- Assert rst while disp_req=1 with credit 20 -> all outputs 0 at once; after release, IDLE and credit 0. disp_ack after release -> no effect.
